sub_decoder: RTL and testbench
==============================

// Module: sub_decoder
//
// PURPOSE
// - One manager fans out to NUM_S subordinates; the inverse of the many-to-one
//   request arbiter.
// - Decodes each request address to a subordinate index and forwards the
//   valid/ready handshake to that subordinate.
// - Records each accepted target in an in-order outstanding FIFO, then routes
//   responses back to the manager strictly in issue order.
// - Control-only: data buses are muxed externally using sel_req / sel_resp.
//
// PARAMETERS
// - NUM_S      2   number of subordinates, 1..2**SEL_BITS
// - ADDR_WIDTH 16  manager address width
// - SEL_BITS   1   address MSBs used for decode: idx = m_req_addr[ADDR_WIDTH-1 -: SEL_BITS]
// - OUT_DEPTH  4   max outstanding requests (power of 2, >=2)
// - IDX_W      localparam, $clog2(NUM_S+1); value NUM_S means "none/error"
//
// PORTS
// - clk           in  1           clock
// - rst           in  1           synchronous, active-high reset
// - m_req_valid   in  1           manager request valid
// - m_req_ready   out 1           manager request ready
// - m_req_addr    in  ADDR_WIDTH  request address
// - s_req_valid   out NUM_S       per-subordinate request valid, at most one hot
// - s_req_ready   in  NUM_S       per-subordinate request ready
// - s_resp_valid  in  NUM_S       per-subordinate response valid
// - s_resp_ready  out NUM_S       per-subordinate response ready, at most one hot
// - m_resp_valid  out 1           manager response valid
// - m_resp_ready  in  1           manager response ready
// - m_resp_err    out 1           response is a decode error (see CONFIGURATION)
// - sel_req       out IDX_W       decoded target of the current request (comb)
// - sel_resp      out IDX_W       target owning the response bus: FIFO head, else NUM_S
// - idle          out 1           no outstanding requests
//
// BEHAVIOUR
// - Reset:
//   - FIFO empty; idle=1; sel_resp=NUM_S.
//   - m_resp_valid=0, m_resp_err=0, s_resp_ready=0.
//   - s_req_valid=0 unless m_req_valid is already high.
// - Decode: idx >= NUM_S is unmapped; target per CONFIGURATION.
// - Request path (combinational, zero latency):
//   - s_req_valid[sel_req] = m_req_valid & !full.
//   - m_req_ready = !full & s_req_ready[sel_req] (internal responder: !full).
// - Accept = m_req_valid & m_req_ready. It pushes sel_req into the FIFO.
// - Response path (combinational from registered FIFO head):
//   - m_resp_valid = s_resp_valid[head], gated by !empty.
//   - s_resp_ready[head] = m_resp_ready.
//   - Pop on m_resp_valid & m_resp_ready.
//   - s_resp_valid from a non-head subordinate is ignored (held off).
// - Latency: a push is visible at the head the next cycle. A response in the
//   same cycle as its own request accept is not observed.
// - Full: m_req_ready=0 even when a pop occurs that cycle. Decided, to keep the
//   ready path short.
// - Empty: m_resp_valid=0 and all s_resp_ready=0, regardless of s_resp_valid.
// - Push and pop in the same cycle: occupancy unchanged; both honoured.
// - Pointers wrap modulo OUT_DEPTH; the occupancy counter is IDX-independent,
//   $clog2(OUT_DEPTH)+1 bits.
// - Target switch with outstanding requests: allowed, because order is
//   preserved by the FIFO.
// - Reset mid-transaction: the FIFO is flushed. Responses still in flight
//   afterwards are dropped (s_resp_ready=0).
//
// CONFIGURATION
// - Macro: SUB_DECODER_DECERR_EN
// - Defined:
//   - Unmapped requests target an internal error responder, index NUM_S.
//   - The responder accepts the request immediately (m_req_ready = !full).
//   - The FIFO records NUM_S.
//   - At the head, it drives m_resp_valid=1 with m_resp_err=1 until
//     m_resp_ready, then pops.
//   - No s_req_valid or s_resp_ready is asserted for it.
// - Undefined:
//   - Unmapped requests alias to subordinate NUM_S-1.
//   - m_resp_err is tied 0; error-responder logic is absent.
//
// STRUCTURE
// - Package sub_decoder_pkg holds the shared decode types and constants:
//   - typedef of the index type (IDX_W bits);
//   - constant IDX_NONE = NUM_S;
//   - function decode(addr) -> idx.
// - Sub-module: the existing sync_fifo, instantiated as outstanding FIFO
//   (DATA_WIDTH=IDX_W, ADDR_SIZE=$clog2(OUT_DEPTH)).
// - All other logic lives inline in this module.
//
// TESTING
// - Single request: NUM_S=2, addr=0x8000 -> s_req_valid=2'b10 and sel_req=1.
//   - Accept, then s_resp_valid[1]=1 next cycle -> m_resp_valid=1, sel_resp=1,
//     pop, idle=1.
// - Ordering: issue to sub0 then sub1; sub1 responds first.
//   - m_resp_valid stays 0 until sub0 responds.
//   - Then sub0 response, then sub1 response, in that order.
// - Backpressure: OUT_DEPTH=4, 4 accepted and no responses -> m_req_ready=0
//   with s_req_ready=1.
//   - One pop -> m_req_ready=1 in the following cycle, not the pop cycle.
// - Simultaneous: at occupancy 2, push and pop in the same cycle -> occupancy
//   stays 2; the head advances correctly.
// - Reset mid-flight: 3 outstanding, assert rst for one cycle -> idle=1,
//   sel_resp=NUM_S.
//   - A later s_resp_valid sees s_resp_ready=0.
// - DECERR (macro defined, NUM_S=3, SEL_BITS=2): addr=0xC000 -> no s_req_valid;
//   m_resp_valid=1 and m_resp_err=1 one cycle later.
//   - With the macro undefined: routed to sub2.

Source files
------------

// File: rtl/sub_decoder_pkg.sv
// Shared decode types and constants for the one-to-many request decoder.
// Unmapped-address handling depends on SUB_DECODER_DECERR_EN.
package sub_decoder_pkg;

  localparam int NUM_S_DFLT = 2;
  localparam int IDX_W_DFLT = $clog2(NUM_S_DFLT + 1);

  typedef logic [IDX_W_DFLT-1:0] idx_t;

  localparam idx_t IDX_NONE = idx_t'(NUM_S_DFLT);

  // Index num_s selects the internal error responder; otherwise unmapped aliases to the last subordinate.
  function automatic int unsigned decode(input logic [31:0] sel, input int unsigned num_s);
    if (sel < num_s) return sel;
`ifdef SUB_DECODER_DECERR_EN
    return num_s;
`else
    return num_s - 1;
`endif
  endfunction

endpackage

// File: rtl/sub_decoder_sync_fifo.sv
// Single-clock FIFO with combinational head read; push/pop are ignored when full/empty.
module sync_fifo #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_SIZE  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  logic [ADDR_SIZE-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  do_push, do_pop;

  assign full    = (cnt_q == (ADDR_SIZE+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/sub_decoder.sv
// One-manager to NUM_S-subordinate handshake decoder with in-order response routing.
// SUB_DECODER_DECERR_EN adds an internal error responder for unmapped addresses.
module sub_decoder
  import sub_decoder_pkg::*;
#(
  parameter int NUM_S      = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int SEL_BITS   = 1,
  parameter int OUT_DEPTH  = 4,
  localparam int IDX_W     = $clog2(NUM_S + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m_req_valid,
  output logic                  m_req_ready,
  input  logic [ADDR_WIDTH-1:0] m_req_addr,
  output logic [NUM_S-1:0]      s_req_valid,
  input  logic [NUM_S-1:0]      s_req_ready,
  input  logic [NUM_S-1:0]      s_resp_valid,
  output logic [NUM_S-1:0]      s_resp_ready,
  output logic                  m_resp_valid,
  input  logic                  m_resp_ready,
  output logic                  m_resp_err,
  output logic [IDX_W-1:0]      sel_req,
  output logic [IDX_W-1:0]      sel_resp,
  output logic                  idle
);

  localparam logic [IDX_W-1:0] IDX_NONE_L = IDX_W'(NUM_S);

  logic                full, empty, push, pop;
  logic [IDX_W-1:0]    head;
  logic [SEL_BITS-1:0] sel_bits;
  logic                unused_addr;

  assign sel_bits    = m_req_addr[ADDR_WIDTH-1 -: SEL_BITS];
  assign unused_addr = ^m_req_addr;
  assign sel_req     = IDX_W'(decode(32'(sel_bits), NUM_S));
  assign sel_resp    = empty ? IDX_NONE_L : head;
  assign idle        = empty;
  assign push        = m_req_valid & m_req_ready;
  assign pop         = m_resp_valid & m_resp_ready;

  // Ready depends on registered full only, so a same-cycle pop never frees a slot.
  always_comb begin
    s_req_valid  = '0;
    m_req_ready  = 1'b0;
    s_resp_ready = '0;
    m_resp_valid = 1'b0;
    m_resp_err   = 1'b0;
    if (!full) begin
`ifdef SUB_DECODER_DECERR_EN
      if (sel_req == IDX_NONE_L) m_req_ready = 1'b1;
`endif
      for (int i = 0; i < NUM_S; i++) begin
        if (sel_req == IDX_W'(i)) begin
          s_req_valid[i] = m_req_valid;
          m_req_ready    = s_req_ready[i];
        end
      end
    end
    if (!empty) begin
`ifdef SUB_DECODER_DECERR_EN
      if (head == IDX_NONE_L) begin
        m_resp_valid = 1'b1;
        m_resp_err   = 1'b1;
      end
`endif
      for (int i = 0; i < NUM_S; i++) begin
        if (head == IDX_W'(i)) begin
          m_resp_valid    = s_resp_valid[i];
          s_resp_ready[i] = m_resp_ready;
        end
      end
    end
  end

  sync_fifo #(
    .DATA_WIDTH(IDX_W),
    .ADDR_SIZE ($clog2(OUT_DEPTH))
  ) u_out_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .wdata(sel_req),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

endmodule

// File: tb/tb_sub_decoder.sv
// Directed bench for sub_decoder: a 2-subordinate instance for routing/ordering
// and a 3-subordinate instance for unmapped-address handling.
module tb_sub_decoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Instance A: NUM_S=2, SEL_BITS=1
  logic        a_m_req_valid, a_m_req_ready, a_m_resp_valid, a_m_resp_ready, a_m_resp_err, a_idle;
  logic [15:0] a_addr;
  logic [1:0]  a_s_req_valid, a_s_req_ready, a_s_resp_valid, a_s_resp_ready;
  logic [1:0]  a_sel_req, a_sel_resp;

  sub_decoder #(.NUM_S(2), .ADDR_WIDTH(16), .SEL_BITS(1), .OUT_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst),
    .m_req_valid(a_m_req_valid), .m_req_ready(a_m_req_ready), .m_req_addr(a_addr),
    .s_req_valid(a_s_req_valid), .s_req_ready(a_s_req_ready),
    .s_resp_valid(a_s_resp_valid), .s_resp_ready(a_s_resp_ready),
    .m_resp_valid(a_m_resp_valid), .m_resp_ready(a_m_resp_ready), .m_resp_err(a_m_resp_err),
    .sel_req(a_sel_req), .sel_resp(a_sel_resp), .idle(a_idle)
  );

  // Instance B: NUM_S=3, SEL_BITS=2 (index 3 unmapped)
  logic        b_m_req_valid, b_m_req_ready, b_m_resp_valid, b_m_resp_ready, b_m_resp_err, b_idle;
  logic [15:0] b_addr;
  logic [2:0]  b_s_req_valid, b_s_req_ready, b_s_resp_valid, b_s_resp_ready;
  logic [1:0]  b_sel_req, b_sel_resp;

  sub_decoder #(.NUM_S(3), .ADDR_WIDTH(16), .SEL_BITS(2), .OUT_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst),
    .m_req_valid(b_m_req_valid), .m_req_ready(b_m_req_ready), .m_req_addr(b_addr),
    .s_req_valid(b_s_req_valid), .s_req_ready(b_s_req_ready),
    .s_resp_valid(b_s_resp_valid), .s_resp_ready(b_s_resp_ready),
    .m_resp_valid(b_m_resp_valid), .m_resp_ready(b_m_resp_ready), .m_resp_err(b_m_resp_err),
    .sel_req(b_sel_req), .sel_resp(b_sel_resp), .idle(b_idle)
  );

  // Step to the next falling edge; comb outputs are sampled 1ns later.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    a_m_req_valid = 0; a_addr = '0; a_s_req_ready = '0; a_s_resp_valid = '0; a_m_resp_ready = 0;
    b_m_req_valid = 0; b_addr = '0; b_s_req_ready = '0; b_s_resp_valid = '0; b_m_resp_ready = 0;
    step(); step();
    #1;
    chk("rst_idle", a_idle, 1);
    chk("rst_sel_resp", a_sel_resp, 2);
    chk("rst_resp_valid", a_m_resp_valid, 0);
    chk("rst_s_resp_ready", a_s_resp_ready, 0);
    chk("rst_err", a_m_resp_err, 0);
    chk("rst_s_req_valid", a_s_req_valid, 0);
    rst = 0;

    // Single request to sub1
    step();
    a_m_req_valid = 1; a_addr = 16'h8000; a_s_req_ready = 2'b11;
    #1;
    chk("single_s_req_valid", a_s_req_valid, 2'b10);
    chk("single_sel_req", a_sel_req, 1);
    chk("single_req_ready", a_m_req_ready, 1);
    step();
    a_m_req_valid = 0; a_s_resp_valid = 2'b10; a_m_resp_ready = 1;
    #1;
    chk("single_resp_valid", a_m_resp_valid, 1);
    chk("single_sel_resp", a_sel_resp, 1);
    chk("single_s_resp_ready", a_s_resp_ready, 2'b10);
    chk("single_busy", a_idle, 0);
    step();
    a_s_resp_valid = 0; a_m_resp_ready = 0;
    #1;
    chk("single_idle", a_idle, 1);

    // Ordering: sub0 then sub1, sub1 answers first
    a_m_req_valid = 1; a_addr = 16'h0000;
    step();
    a_addr = 16'h8000;
    #1;
    chk("ord_push1_ready", a_m_req_ready, 1);
    step();
    a_m_req_valid = 0; a_s_resp_valid = 2'b10; a_m_resp_ready = 1;
    #1;
    chk("ord_held_valid", a_m_resp_valid, 0);
    chk("ord_held_sel", a_sel_resp, 0);
    chk("ord_held_ready", a_s_resp_ready, 2'b01);
    step();
    a_s_resp_valid = 2'b11;
    #1;
    chk("ord_first_valid", a_m_resp_valid, 1);
    chk("ord_first_sel", a_sel_resp, 0);
    step();
    a_s_resp_valid = 2'b10;
    #1;
    chk("ord_second_valid", a_m_resp_valid, 1);
    chk("ord_second_sel", a_sel_resp, 1);
    step();
    a_s_resp_valid = 0; a_m_resp_ready = 0;
    #1;
    chk("ord_idle", a_idle, 1);

    // Backpressure: fill 4 with no responses
    for (int i = 0; i < 4; i++) begin
      a_m_req_valid = 1; a_addr = 16'h0000;
      #1;
      chk("bp_fill_ready", a_m_req_ready, 1);
      step();
    end
    #1;
    chk("bp_full_ready", a_m_req_ready, 0);
    chk("bp_full_s_req_valid", a_s_req_valid, 0);
    a_s_resp_valid = 2'b01; a_m_resp_ready = 1;
    #1;
    chk("bp_pop_cycle_ready", a_m_req_ready, 0);
    chk("bp_pop_cycle_valid", a_m_resp_valid, 1);
    step();
    a_s_resp_valid = 0; a_m_resp_ready = 0;
    #1;
    chk("bp_after_pop_ready", a_m_req_ready, 1);
    a_m_req_valid = 0;

    // Reset mid-flight with 3 outstanding
    step();
    chk("rf_busy", a_idle, 0);
    rst = 1;
    step();
    rst = 0;
    #1;
    chk("rf_idle", a_idle, 1);
    chk("rf_sel_resp", a_sel_resp, 2);
    a_s_resp_valid = 2'b01; a_m_resp_ready = 1;
    #1;
    chk("rf_s_resp_ready", a_s_resp_ready, 0);
    chk("rf_resp_valid", a_m_resp_valid, 0);
    step();
    a_s_resp_valid = 0; a_m_resp_ready = 0;

    // Simultaneous push/pop at occupancy 2
    a_m_req_valid = 1; a_addr = 16'h8000;
    step();
    a_addr = 16'h0000;
    step();
    a_addr = 16'h8000; a_s_resp_valid = 2'b10; a_m_resp_ready = 1;
    #1;
    chk("sim_push_ready", a_m_req_ready, 1);
    chk("sim_pop_valid", a_m_resp_valid, 1);
    chk("sim_pop_sel", a_sel_resp, 1);
    step();
    a_m_req_valid = 0; a_s_resp_valid = 2'b01;
    #1;
    chk("sim_head0_sel", a_sel_resp, 0);
    chk("sim_head0_valid", a_m_resp_valid, 1);
    step();
    a_s_resp_valid = 2'b10;
    #1;
    chk("sim_head1_sel", a_sel_resp, 1);
    chk("sim_head1_valid", a_m_resp_valid, 1);
    step();
    a_s_resp_valid = 0; a_m_resp_ready = 0;
    #1;
    chk("sim_idle", a_idle, 1);

    // Instance B: mapped sub1, then unmapped index 3
    b_m_req_valid = 1; b_addr = 16'h4000; b_s_req_ready = 3'b111;
    #1;
    chk("b_map_s_req_valid", b_s_req_valid, 3'b010);
    b_m_req_valid = 0;
    #1;
    b_m_req_valid = 1; b_addr = 16'hC000;
    #1;
`ifdef SUB_DECODER_DECERR_EN
    chk("b_err_s_req_valid", b_s_req_valid, 0);
    chk("b_err_sel_req", b_sel_req, 3);
    chk("b_err_req_ready", b_m_req_ready, 1);
    step();
    b_m_req_valid = 0; b_m_resp_ready = 1;
    #1;
    chk("b_err_resp_valid", b_m_resp_valid, 1);
    chk("b_err_resp_err", b_m_resp_err, 1);
    chk("b_err_sel_resp", b_sel_resp, 3);
    chk("b_err_s_resp_ready", b_s_resp_ready, 0);
`else
    chk("b_alias_s_req_valid", b_s_req_valid, 3'b100);
    chk("b_alias_sel_req", b_sel_req, 2);
    chk("b_alias_req_ready", b_m_req_ready, 1);
    step();
    b_m_req_valid = 0; b_m_resp_ready = 1; b_s_resp_valid = 3'b100;
    #1;
    chk("b_alias_resp_valid", b_m_resp_valid, 1);
    chk("b_alias_resp_err", b_m_resp_err, 0);
    chk("b_alias_sel_resp", b_sel_resp, 2);
    chk("b_alias_s_resp_ready", b_s_resp_ready, 3'b100);
`endif
    step();
    b_m_resp_ready = 0; b_s_resp_valid = 0;
    #1;
    chk("b_idle", b_idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
